// File: rtl/reaction_sequencer.sv
// ---------------------------------------------------------------------------
// reaction_sequencer
//
// Top-level sequencer for the reaction-timer datapath. A start pulse clears
// the BCD delay counter and arms a pseudo-random foreperiod, clamped to
// [MIN_DELAY, MAX_DELAY] milliseconds. When the foreperiod expires the
// stimulus LED lights and every 1 ms tick is forwarded to the counter chain
// until the player presses stop. Early presses and over-long reactions are
// flagged, and the result is held for display until the next start or clear.
//
// Ports:
//   clk              system clock
//   rst_n            synchronous active-low reset
//   start            debounced single-cycle start pulse
//   stop             debounced single-cycle reaction button pulse
//   clear            single-cycle abort, returns to IDLE from any state
//   tick_1ms         single-cycle enable, one per millisecond
//   rand_delay       free-running random value, sampled in ARM
//   error_long_delay overflow flag from the BCD counter chain
//   time_clr         clear to the BCD counter chain
//   record_wait      count enable to the least-significant BCD digit
//   stop_cnt         freeze to the BCD counter chain
//   led_on           stimulus LED
//   busy             a round is in progress
//   status           0=IDLE 1=WAITING 2=REACTING 3=DONE_OK 4=ERR_EARLY
//                    5=ERR_SLOW
// ---------------------------------------------------------------------------
module reaction_sequencer #(
  parameter int DELAY_W   = 14,
  parameter int MIN_DELAY = 1000,
  parameter int MAX_DELAY = 5000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               stop,
  input  logic               clear,
  input  logic               tick_1ms,
  input  logic [DELAY_W-1:0] rand_delay,
  input  logic               error_long_delay,
  output logic               time_clr,
  output logic               record_wait,
  output logic               stop_cnt,
  output logic               led_on,
  output logic               busy,
  output logic [2:0]         status
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_ARM       = 3'd1,
    S_WAIT_RAND = 3'd2,
    S_REACT     = 3'd3,
    S_DONE_OK   = 3'd4,
    S_ERR_EARLY = 3'd5,
    S_ERR_SLOW  = 3'd6
  } state_t;

  localparam logic [DELAY_W-1:0] MIN_L = DELAY_W'(MIN_DELAY);
  localparam logic [DELAY_W-1:0] MAX_L = DELAY_W'(MAX_DELAY);
  localparam logic [DELAY_W-1:0] ONE_L = DELAY_W'(1);

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_WAITING   = 3'd1;
  localparam logic [2:0] ST_REACTING  = 3'd2;
  localparam logic [2:0] ST_DONE_OK   = 3'd3;
  localparam logic [2:0] ST_ERR_EARLY = 3'd4;
  localparam logic [2:0] ST_ERR_SLOW  = 3'd5;

  state_t             r_state;
  state_t             w_stateNext;
  logic [DELAY_W-1:0] r_waitCnt;
  logic [DELAY_W-1:0] w_clampedDelay;
  logic               w_lastTick;

  // Bound the raw random value so the foreperiod is never shorter than
  // MIN_DELAY (which also keeps the countdown from starting at zero) and
  // never longer than MAX_DELAY.
  always_comb begin
    w_clampedDelay = rand_delay;
    if (rand_delay < MIN_L) begin
      w_clampedDelay = MIN_L;
    end else if (rand_delay > MAX_L) begin
      w_clampedDelay = MAX_L;
    end
  end

  // The tick that finds one millisecond remaining ends the foreperiod, so a
  // loaded value of D lets exactly D ticks elapse before the LED lights.
  assign w_lastTick = tick_1ms && (r_waitCnt == ONE_L);

  // State register. Reset is sampled on the clock edge like any other input.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  // Foreperiod countdown. Loaded once in ARM and only ever decremented while
  // waiting, so a stray start during the wait cannot reload it. The decrement
  // is held off when stop or clear ends the wait in the same cycle, which
  // leaves a meaningful remaining value behind for debug.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_waitCnt <= '0;
    end else if (r_state == S_ARM && !clear) begin
      r_waitCnt <= w_clampedDelay;
    end else if (r_state == S_WAIT_RAND && tick_1ms && !stop && !clear) begin
      r_waitCnt <= r_waitCnt - ONE_L;
    end
  end

  // Next-state logic. clear beats everything; within a state the player's
  // stop press beats both foreperiod expiry and counter overflow, so a press
  // that lands on the same cycle is always judged in the player's favour
  // (or against them, for an early press).
  always_comb begin
    w_stateNext = r_state;
    if (clear) begin
      w_stateNext = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            w_stateNext = S_ARM;
          end
        end
        S_ARM: begin
          w_stateNext = S_WAIT_RAND;
        end
        S_WAIT_RAND: begin
          if (stop) begin
            w_stateNext = S_ERR_EARLY;
          end else if (w_lastTick) begin
            w_stateNext = S_REACT;
          end
        end
        S_REACT: begin
          if (stop) begin
            w_stateNext = S_DONE_OK;
          end else if (error_long_delay) begin
            w_stateNext = S_ERR_SLOW;
          end
        end
        S_DONE_OK, S_ERR_EARLY, S_ERR_SLOW: begin
          if (start) begin
            w_stateNext = S_ARM;
          end
        end
        default: begin
          w_stateNext = S_IDLE;
        end
      endcase
    end
  end

  // Output decode. Everything except record_wait is a pure function of the
  // state register; record_wait passes the live tick through so the counter
  // advances on the same edge as the tick, and masks it on the stop cycle so
  // the press itself is not counted.
  always_comb begin
    time_clr    = 1'b0;
    record_wait = 1'b0;
    stop_cnt    = 1'b0;
    led_on      = 1'b0;
    busy        = 1'b0;
    status      = ST_IDLE;
    case (r_state)
      S_IDLE: begin
        time_clr = 1'b1;
      end
      S_ARM: begin
        time_clr = 1'b1;
        busy     = 1'b1;
        status   = ST_WAITING;
      end
      S_WAIT_RAND: begin
        busy   = 1'b1;
        status = ST_WAITING;
      end
      S_REACT: begin
        led_on      = 1'b1;
        busy        = 1'b1;
        status      = ST_REACTING;
        record_wait = tick_1ms && !stop;
      end
      S_DONE_OK: begin
        stop_cnt = 1'b1;
        status   = ST_DONE_OK;
      end
      S_ERR_EARLY: begin
        stop_cnt = 1'b1;
        status   = ST_ERR_EARLY;
      end
      S_ERR_SLOW: begin
        stop_cnt = 1'b1;
        status   = ST_ERR_SLOW;
      end
      default: begin
        time_clr = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_reaction_sequencer.sv
// ---------------------------------------------------------------------------
// tb_reaction_sequencer
//
// Self-checking bench for reaction_sequencer. A behavioural model tracks the
// round as a phase plus "ticks elapsed versus foreperiod" and "reaction ticks
// recorded", and every cycle the DUT outputs are compared against what that
// phase implies. Directed rounds pin the model with hand-computed numbers,
// then randomized rounds stress it.
// ---------------------------------------------------------------------------
module tb_reaction_sequencer;

  localparam int DELAY_W = 14;
  localparam int MIN_D   = 1000;
  localparam int MAX_D   = 5000;

  localparam int P_IDLE     = 0;
  localparam int P_WAITING  = 1;
  localparam int P_REACTING = 2;
  localparam int P_DONE     = 3;
  localparam int P_EARLY    = 4;
  localparam int P_SLOW     = 5;
  localparam int P_ARMING   = 6;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               start;
  logic               stop;
  logic               clear;
  logic               tick_1ms;
  logic [DELAY_W-1:0] rand_delay;
  logic               error_long_delay;
  logic               time_clr;
  logic               record_wait;
  logic               stop_cnt;
  logic               led_on;
  logic               busy;
  logic [2:0]         status;

  int vectors     = 0;
  int miscompares = 0;

  int mPhase    = P_IDLE;
  int mFore     = 0;
  int mTicks    = 0;
  int mPulses   = 0;
  bit modelLive = 1'b0;

  int dutPulses = 0;
  bit ledSeen   = 1'b0;

  always #5 clk = ~clk;

  reaction_sequencer #(
    .DELAY_W  (DELAY_W),
    .MIN_DELAY(MIN_D),
    .MAX_DELAY(MAX_D)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .start           (start),
    .stop            (stop),
    .clear           (clear),
    .tick_1ms        (tick_1ms),
    .rand_delay      (rand_delay),
    .error_long_delay(error_long_delay),
    .time_clr        (time_clr),
    .record_wait     (record_wait),
    .stop_cnt        (stop_cnt),
    .led_on          (led_on),
    .busy            (busy),
    .status          (status)
  );

  function automatic int clampDelay(int d);
    if (d < MIN_D) return MIN_D;
    if (d > MAX_D) return MAX_D;
    return d;
  endfunction

  task automatic checkVal(string name, int act, int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: advances one round step per clock from the inputs the
  // DUT is sampling on the same edge.
  always @(posedge clk) begin
    modelLive = 1'b1;
    if (!rst_n || clear) begin
      mPhase = P_IDLE;
    end else begin
      case (mPhase)
        P_IDLE: if (start) mPhase = P_ARMING;
        P_ARMING: begin
          mFore   = clampDelay(int'(rand_delay));
          mTicks  = 0;
          mPulses = 0;
          mPhase  = P_WAITING;
        end
        P_WAITING: begin
          if (stop) begin
            mPhase = P_EARLY;
          end else if (tick_1ms) begin
            mTicks++;
            if (mTicks == mFore) mPhase = P_REACTING;
          end
        end
        P_REACTING: begin
          if (tick_1ms && !stop) mPulses++;
          if (stop) mPhase = P_DONE;
          else if (error_long_delay) mPhase = P_SLOW;
        end
        default: if (start) mPhase = P_ARMING;
      endcase
    end
  end

  // Observe the counter-facing outputs the way the BCD chain would: count
  // enables since the last clear, and note whether the LED was ever lit.
  always @(posedge clk) begin
    if (time_clr) begin
      dutPulses = 0;
      ledSeen   = 1'b0;
    end else begin
      if (record_wait) dutPulses++;
      if (led_on) ledSeen = 1'b1;
    end
  end

  // Per-cycle comparison against the model, taken mid-cycle while the
  // inputs for the coming edge are stable.
  always @(negedge clk) begin
    if (modelLive) begin
      checkVal("status", int'(status), (mPhase == P_ARMING) ? 1 : mPhase);
      checkVal("time_clr", int'(time_clr), int'(mPhase == P_IDLE || mPhase == P_ARMING));
      checkVal("busy", int'(busy),
               int'(mPhase == P_ARMING || mPhase == P_WAITING || mPhase == P_REACTING));
      checkVal("led_on", int'(led_on), int'(mPhase == P_REACTING));
      checkVal("stop_cnt", int'(stop_cnt), int'(mPhase >= P_DONE && mPhase <= P_SLOW));
      checkVal("record_wait", int'(record_wait),
               int'(mPhase == P_REACTING && tick_1ms && !stop));
    end
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idleInputs();
    start            = 1'b0;
    stop             = 1'b0;
    clear            = 1'b0;
    tick_1ms         = 1'b0;
    error_long_delay = 1'b0;
  endtask

  // Start pulse, then the ARM cycle; returns with the DUT waiting.
  task automatic startRound(int d);
    logic [31:0] dv;
    dv         = d;
    rand_delay = dv[DELAY_W-1:0];
    start      = 1'b1;
    cycle();
    start = 1'b0;
    cycle();
  endtask

  // Hold tick high and count ticks until the LED lights.
  task automatic measureWait(output int n);
    tick_1ms = 1'b1;
    n = 0;
    while (!led_on && n < 20000) begin
      cycle();
      n++;
    end
    tick_1ms = 1'b0;
  endtask

  // k counted ticks, then a stop press on a tick cycle.
  task automatic reactFor(int k);
    tick_1ms = 1'b1;
    repeat (k) cycle();
    stop = 1'b1;
    cycle();
    stop     = 1'b0;
    tick_1ms = 1'b0;
  endtask

  task automatic pulseClear();
    clear = 1'b1;
    cycle();
    clear = 1'b0;
  endtask

  task automatic applyStimulus();
    int n;
    int cnt;
    int d;

    // Random rounds: random tick density, stray starts, random press timing,
    // occasional overflow and abort.
    for (int r = 0; r < 10; r++) begin
      d = $urandom_range(0, 2200);
      startRound(d);
      cnt = 0;
      while ((mPhase == P_ARMING || mPhase == P_WAITING || mPhase == P_REACTING)
             && cnt < 20000) begin
        tick_1ms         = ($urandom_range(0, 3) != 0);
        start            = ($urandom_range(0, 39) == 0);
        clear            = ($urandom_range(0, 3999) == 0);
        rand_delay       = DELAY_W'($urandom_range(0, 16383));
        stop             = (mPhase == P_REACTING) ? ($urandom_range(0, 149) == 0)
                                                  : ($urandom_range(0, 2999) == 0);
        error_long_delay = (mPhase == P_REACTING) && ($urandom_range(0, 299) == 0);
        cycle();
        cnt++;
      end
      idleInputs();
      repeat (2) cycle();
    end

    // Normal round and a second hold of the same timing after a restart.
    pulseClear();
    startRound(2000);
    measureWait(n);
    checkVal("normal_foreperiod", n, 2000);
    reactFor(347);
    checkVal("normal_status", int'(status), 3);
    checkVal("normal_bcd", dutPulses, 347);
    checkVal("model_pulses", mPulses, 347);
    checkVal("normal_stop_cnt", int'(stop_cnt), 1);

    rand_delay = 14'd3000;
    start = 1'b1;
    cycle();
    start = 1'b0;
    checkVal("restart_arm_clr", int'(time_clr), 1);
    checkVal("restart_arm_status", int'(status), 1);
    cycle();
    checkVal("restart_wait_clr", int'(time_clr), 0);
    measureWait(n);
    checkVal("restart_foreperiod", n, 3000);
    reactFor(347);
    checkVal("restart_bcd", dutPulses, 347);

    // Clamping, with an abort from REACT on the low clamp.
    startRound(12);
    measureWait(n);
    checkVal("clamp_low", n, 1000);
    pulseClear();
    checkVal("clear_status", int'(status), 0);
    checkVal("clear_time_clr", int'(time_clr), 1);
    checkVal("clear_led", int'(led_on), 0);

    startRound(9000);
    measureWait(n);
    checkVal("clamp_high", n, 5000);
    reactFor(5);

    // Boundary foreperiod, then a slow reaction.
    startRound(1000);
    measureWait(n);
    checkVal("clamp_boundary", n, 1000);
    repeat (3) cycle();
    error_long_delay = 1'b1;
    cycle();
    error_long_delay = 1'b0;
    checkVal("slow_status", int'(status), 5);
    checkVal("slow_stop_cnt", int'(stop_cnt), 1);
    checkVal("slow_led", int'(led_on), 0);

    // Overflow and stop together: stop wins, tick on that cycle not counted.
    startRound(1000);
    measureWait(n);
    error_long_delay = 1'b1;
    stop             = 1'b1;
    tick_1ms         = 1'b1;
    cycle();
    idleInputs();
    checkVal("tie_status", int'(status), 3);
    checkVal("tie_bcd", dutPulses, 0);

    // Early press at tick 500 of a 2000 tick wait.
    startRound(2000);
    tick_1ms = 1'b1;
    repeat (499) cycle();
    stop = 1'b1;
    cycle();
    idleInputs();
    checkVal("early_status", int'(status), 4);
    checkVal("early_led_seen", int'(ledSeen), 0);
    checkVal("early_bcd", dutPulses, 0);

    // Press on the very tick that would have expired the foreperiod.
    startRound(1000);
    tick_1ms = 1'b1;
    repeat (999) cycle();
    stop = 1'b1;
    cycle();
    idleInputs();
    checkVal("early_edge_status", int'(status), 4);
    checkVal("early_edge_led_seen", int'(ledSeen), 0);

    // A start during the wait must not reload the foreperiod.
    startRound(2000);
    tick_1ms = 1'b1;
    repeat (500) cycle();
    start      = 1'b1;
    rand_delay = 14'd1000;
    cycle();
    start = 1'b0;
    measureWait(n);
    checkVal("start_in_wait", n + 501, 2000);
    reactFor(10);

    // Reset in the middle of the wait.
    startRound(2000);
    tick_1ms = 1'b1;
    repeat (100) cycle();
    tick_1ms = 1'b0;
    rst_n    = 1'b0;
    cycle();
    checkVal("rst_status", int'(status), 0);
    checkVal("rst_time_clr", int'(time_clr), 1);
    checkVal("rst_busy", int'(busy), 0);
    checkVal("rst_led", int'(led_on), 0);
    checkVal("rst_stop_cnt", int'(stop_cnt), 0);
    checkVal("rst_record_wait", int'(record_wait), 0);
    rst_n = 1'b1;
    cycle();
  endtask

  task automatic checkOutput();
    $display("[TB] == %0d vectors applied, %0d miscompares ==", vectors, miscompares);
  endtask

  initial begin
    rst_n      = 1'b0;
    rand_delay = '0;
    idleInputs();
    repeat (3) cycle();
    checkVal("reset_status", int'(status), 0);
    checkVal("reset_time_clr", int'(time_clr), 1);
    checkVal("reset_busy", int'(busy), 0);
    checkVal("reset_led", int'(led_on), 0);
    rst_n = 1'b1;
    cycle();
    applyStimulus();
    checkOutput();
    $finish;
  end

endmodule
